tx_link_ctrl: RTL and testbench
===============================

Name: tx_link_ctrl

Overview:
- Sequencing controller for the JESD204B TX link layer.
- Owns the LMFC/frame timing and follows the receiver's SYNC~ to drive the link layer's stream-select (0 user data, 1 continuous K, 2 ILA) and the captured frame position.
- Sequence is CGS, then ILA aligned to an LMFC boundary, then user data.
- Detects resync requests and short SYNC~ error pulses during data phase.

Parameters:
- F_OCTETS, 8, octets per frame (1..256).
- K_FRAMES, 4, frames per multiframe (1..32).
- ILA_MF, 4, multiframes in the ILA sequence (1..255).
- RESYNC_OCT, 5*F_OCTETS+9, consecutive SYNC~-low cycles in DATA that force resync.

Ports:
- clk  in  1  character clock.
- rst_n  in  1  asynchronous active-low reset.
- i_link_en  in  1  link enable; low forces CGS.
- i_sync_n  in  1  SYNC~ from receiver; already synchronous to clk (synchronised upstream).
- o_link_mux  out  3  stream select to the link layer: 0 data, 1 K, 2 ILA.
- o_no_frame_de_assertion  out  5  frame index captured at SYNC~ de-assertion.
- o_lmfc_pulse  out  1  high on last octet of each multiframe.
- o_frame_pulse  out  1  high on last octet of each frame.
- o_state  out  2  0 CGS, 1 WAIT_LMFC, 2 ILA, 3 DATA.
- o_sync_err  out  1  one-cycle pulse on a short SYNC~ low pulse in DATA.
- o_resync  out  1  one-cycle pulse when a resync returns the link to CGS.

Behaviour:
- Reset (async assert, sync release):
  - state=CGS, o_link_mux=1, o_no_frame_de_assertion=0.
  - All pulses 0, octet_cnt=0, frame_cnt=0, ila_cnt=0, low_cnt=0.
- Counters free-run from reset release, independent of state:
  - octet_cnt runs 0..F_OCTETS-1, wraps to 0.
  - frame_cnt increments when octet_cnt wraps, runs 0..K_FRAMES-1, wraps to 0.
  - Pulse outputs are registered, asserting in the cycle where the counters show the condition:
    - o_frame_pulse when octet_cnt==F_OCTETS-1.
    - o_lmfc_pulse when additionally frame_cnt==K_FRAMES-1.
  - F_OCTETS=1 → o_frame_pulse constantly high. K_FRAMES=1 → o_lmfc_pulse equals o_frame_pulse.
- FSM transitions (all registered; o_link_mux and o_state update on the same edge as state):
  - CGS (mux=1): i_link_en=1 and i_sync_n=1 → WAIT_LMFC. On that edge, o_no_frame_de_assertion <= frame_cnt.
  - WAIT_LMFC (mux=1):
    - i_sync_n=0 → CGS.
    - Else, on the o_lmfc_pulse cycle → ILA, with ila_cnt=0.
    - The first ILA octet therefore coincides with octet_cnt=0, frame_cnt=0.
  - ILA (mux=2):
    - ila_cnt increments on each o_lmfc_pulse.
    - On the o_lmfc_pulse with ila_cnt==ILA_MF-1 → DATA.
    - i_sync_n=0 → CGS.
    - ILA length is exactly ILA_MF*K_FRAMES*F_OCTETS cycles.
  - DATA (mux=0):
    - low_cnt counts consecutive i_sync_n=0 cycles (saturating); it clears when i_sync_n=1.
    - When low_cnt reaches RESYNC_OCT-1 with i_sync_n still 0 → CGS, o_resync pulse. The transition edge is the RESYNC_OCT-th low cycle.
    - If i_sync_n returns to 1 with 0<low_cnt<RESYNC_OCT → o_sync_err pulse on that edge; stay in DATA.
  - Any state, i_link_en=0 → CGS (priority over everything). No o_resync pulse, low_cnt cleared.
- Simultaneous events:
  - In WAIT_LMFC or ILA, i_sync_n=0 on an o_lmfc_pulse cycle → CGS wins.
  - An i_link_en drop outranks a resync.
- After CGS re-entry, a new SYNC~ rise restarts the full sequence. The counters are not reset.
- ILA boundary: ila_cnt is 8 bits; ILA_MF=1 gives a single-multiframe ILA.

Decomposition:
- Shared package tx_link_pkg:
  - mux select constants LINK_MUX_DATA=0, LINK_MUX_K=1, LINK_MUX_ILA=2.
  - state encodings ST_CGS..ST_DATA.
  - widths OCT_W=8, FRM_W=5.
- One natural sub-module, lmfc_counter: octet/frame counters plus o_frame_pulse and o_lmfc_pulse generation. The FSM stays in tx_link_ctrl.

Test Plan (F_OCTETS=8, K_FRAMES=4, ILA_MF=4, RESYNC_OCT=49; multiframe = 32 cycles):
1. Reset held, then released with i_sync_n=0 → o_link_mux=1 and o_state=0 for 100 cycles; o_lmfc_pulse every 32 cycles.
2. SYNC~ rise while frame_cnt=2 → o_no_frame_de_assertion=2 and state WAIT_LMFC. mux=2 starts at the next octet_cnt=0/frame_cnt=0, lasts exactly 128 cycles, then mux=0.
3. In DATA, i_sync_n low for 20 cycles → one o_sync_err pulse on the rising edge; mux stays 0; no o_resync.
4. In DATA, i_sync_n low for 49 cycles → o_resync pulse and mux=1 on the 49th low cycle. A low of 48 cycles gives o_sync_err instead.
5. In ILA at ila_cnt=2, i_sync_n drops → CGS, mux=1 next cycle. A later SYNC~ rise re-runs the full 128-cycle ILA.
6. In DATA, i_link_en=0 for 1 cycle → CGS, no o_resync. rst_n asserted mid-ILA → outputs immediately take their reset values, without waiting for a clock edge.

Source files
------------

// File: rtl/tx_link_pkg.sv
// Shared types and constants for the JESD204B TX link sequencing controller.
package tx_link_pkg;

  localparam int unsigned OCT_W = 8;
  localparam int unsigned FRM_W = 5;

  localparam logic [2:0] LINK_MUX_DATA = 3'd0;
  localparam logic [2:0] LINK_MUX_K    = 3'd1;
  localparam logic [2:0] LINK_MUX_ILA  = 3'd2;

  typedef enum logic [1:0] {
    ST_CGS       = 2'd0,
    ST_WAIT_LMFC = 2'd1,
    ST_ILA       = 2'd2,
    ST_DATA      = 2'd3
  } link_state_e;

  function automatic logic [2:0] state_to_mux(input link_state_e st);
    logic [2:0] mux;
    case (st)
      ST_ILA:  mux = LINK_MUX_ILA;
      ST_DATA: mux = LINK_MUX_DATA;
      default: mux = LINK_MUX_K;
    endcase
    return mux;
  endfunction

endpackage

// File: rtl/lmfc_counter.sv
// Free-running octet/frame counters with registered frame and LMFC pulses.
module lmfc_counter
  import tx_link_pkg::*;
#(
  parameter int unsigned F_OCTETS = 8,
  parameter int unsigned K_FRAMES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [FRM_W-1:0] frame_cnt,
  output logic             frame_pulse,
  output logic             lmfc_pulse
);

  localparam logic [OCT_W-1:0] OCT_LAST = OCT_W'(F_OCTETS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(K_FRAMES - 1);

  logic [OCT_W-1:0] octet_cnt;
  logic [OCT_W-1:0] octet_d;
  logic [FRM_W-1:0] frame_d;
  logic             octet_wrap;

  always_comb begin
    octet_wrap = (octet_cnt == OCT_LAST);
    octet_d    = octet_wrap ? '0 : octet_cnt + OCT_W'(1);
    frame_d    = frame_cnt;
    if (octet_wrap) begin
      frame_d = (frame_cnt == FRM_LAST) ? '0 : frame_cnt + FRM_W'(1);
    end
  end

  // Pulses are computed from the next counter values so they line up with the count they flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      octet_cnt   <= '0;
      frame_cnt   <= '0;
      frame_pulse <= 1'b0;
      lmfc_pulse  <= 1'b0;
    end else begin
      octet_cnt   <= octet_d;
      frame_cnt   <= frame_d;
      frame_pulse <= (octet_d == OCT_LAST);
      lmfc_pulse  <= (octet_d == OCT_LAST) && (frame_d == FRM_LAST);
    end
  end

endmodule

// File: rtl/tx_link_ctrl.sv
// JESD204B TX link sequencing: CGS -> LMFC-aligned ILA -> user data, with SYNC~ error/resync
// detection during the data phase.
module tx_link_ctrl
  import tx_link_pkg::*;
#(
  parameter int unsigned F_OCTETS   = 8,
  parameter int unsigned K_FRAMES   = 4,
  parameter int unsigned ILA_MF     = 4,
  parameter int unsigned RESYNC_OCT = 5 * F_OCTETS + 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_link_en,
  input  logic             i_sync_n,
  output logic [2:0]       o_link_mux,
  output logic [FRM_W-1:0] o_no_frame_de_assertion,
  output logic             o_lmfc_pulse,
  output logic             o_frame_pulse,
  output logic [1:0]       o_state,
  output logic             o_sync_err,
  output logic             o_resync
);

  localparam int unsigned      LOW_W    = $clog2(RESYNC_OCT + 1);
  localparam logic [LOW_W-1:0] LOW_LAST = LOW_W'(RESYNC_OCT - 1);
  localparam logic [7:0]       ILA_LAST = 8'(ILA_MF - 1);

  link_state_e      state_q, state_d;
  logic [7:0]       ila_q, ila_d;
  logic [LOW_W-1:0] low_q, low_d;
  logic [FRM_W-1:0] nfr_q, nfr_d;
  logic [2:0]       mux_q;
  logic             sync_err_q, sync_err_d;
  logic             resync_q, resync_d;
  logic [FRM_W-1:0] frame_cnt;
  logic             lmfc_pulse;

  lmfc_counter #(
    .F_OCTETS (F_OCTETS),
    .K_FRAMES (K_FRAMES)
  ) u_lmfc_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_cnt   (frame_cnt),
    .frame_pulse (o_frame_pulse),
    .lmfc_pulse  (lmfc_pulse)
  );

  always_comb begin
    state_d    = state_q;
    ila_d      = ila_q;
    low_d      = '0;
    nfr_d      = nfr_q;
    sync_err_d = 1'b0;
    resync_d   = 1'b0;
    if (!i_link_en) begin
      state_d = ST_CGS;
    end else begin
      unique case (state_q)
        ST_CGS: begin
          if (i_sync_n) begin
            state_d = ST_WAIT_LMFC;
            nfr_d   = frame_cnt;
          end
        end
        ST_WAIT_LMFC: begin
          if (!i_sync_n) begin
            state_d = ST_CGS;
          end else if (lmfc_pulse) begin
            state_d = ST_ILA;
            ila_d   = '0;
          end
        end
        ST_ILA: begin
          if (!i_sync_n) begin
            state_d = ST_CGS;
          end else if (lmfc_pulse) begin
            ila_d = ila_q + 8'd1;
            if (ila_q == ILA_LAST) state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          if (!i_sync_n) begin
            if (low_q == LOW_LAST) begin
              state_d  = ST_CGS;
              resync_d = 1'b1;
            end else begin
              low_d = low_q + LOW_W'(1);
            end
          end else if (low_q != '0) begin
            // Low run ended before the resync threshold: receiver flagged an error.
            sync_err_d = 1'b1;
          end
        end
        default: state_d = ST_CGS;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CGS;
      ila_q      <= '0;
      low_q      <= '0;
      nfr_q      <= '0;
      mux_q      <= LINK_MUX_K;
      sync_err_q <= 1'b0;
      resync_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ila_q      <= ila_d;
      low_q      <= low_d;
      nfr_q      <= nfr_d;
      mux_q      <= state_to_mux(state_d);
      sync_err_q <= sync_err_d;
      resync_q   <= resync_d;
    end
  end

  assign o_link_mux              = mux_q;
  assign o_no_frame_de_assertion = nfr_q;
  assign o_lmfc_pulse            = lmfc_pulse;
  assign o_state                 = state_q;
  assign o_sync_err              = sync_err_q;
  assign o_resync                = resync_q;

endmodule

// File: tb/tb_tx_link_ctrl.sv
// Self-checking bench for tx_link_ctrl: directed phases plus random SYNC~/enable traffic,
// compared every cycle against a timeline-based reference model.
module tb_tx_link_ctrl;

  localparam int F       = 8;
  localparam int K       = 4;
  localparam int ILA     = 4;
  localparam int RS      = 49;
  localparam int MF      = F * K;
  localparam int ILA_LEN = ILA * MF;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       link_en;
  logic       sync_n;
  logic [2:0] o_link_mux;
  logic [4:0] o_no_frame_de_assertion;
  logic       o_lmfc_pulse;
  logic       o_frame_pulse;
  logic [1:0] o_state;
  logic       o_sync_err;
  logic       o_resync;

  int errors = 0;
  int checks = 0;

  // Reference model: m_t is the number of clock edges since reset release.
  int m_st;
  int m_t;
  int m_ila_start;
  int m_low;
  int m_cap;
  bit m_err;
  bit m_rs;

  tx_link_ctrl #(
    .F_OCTETS   (F),
    .K_FRAMES   (K),
    .ILA_MF     (ILA),
    .RESYNC_OCT (RS)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .i_link_en               (link_en),
    .i_sync_n                (sync_n),
    .o_link_mux              (o_link_mux),
    .o_no_frame_de_assertion (o_no_frame_de_assertion),
    .o_lmfc_pulse            (o_lmfc_pulse),
    .o_frame_pulse           (o_frame_pulse),
    .o_state                 (o_state),
    .o_sync_err              (o_sync_err),
    .o_resync                (o_resync)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s at t=%0t: observed %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int mux_of(input int st);
    if (st == 3) return 0;
    if (st == 2) return 2;
    return 1;
  endfunction

  function automatic int cur_oct();
    return m_t % F;
  endfunction

  function automatic int cur_frm();
    return (m_t / F) % K;
  endfunction

  task automatic model_reset();
    m_st  = 0;
    m_t   = 0;
    m_low = 0;
    m_cap = 0;
    m_err = 1'b0;
    m_rs  = 1'b0;
    m_ila_start = 0;
  endtask

  task automatic model_edge(input logic s, input logic e);
    bit lmfc_now;
    lmfc_now = (cur_oct() == F - 1) && (cur_frm() == K - 1);
    m_err = 1'b0;
    m_rs  = 1'b0;
    if (!e) begin
      m_st = 0;
    end else if (m_st == 0) begin
      if (s) begin
        m_st  = 1;
        m_cap = cur_frm();
      end
    end else if (m_st == 1) begin
      if (!s) m_st = 0;
      else if (lmfc_now) begin
        m_st = 2;
        m_ila_start = m_t + 1;
      end
    end else if (m_st == 2) begin
      if (!s) m_st = 0;
      else if (m_t + 1 - m_ila_start == ILA_LEN) m_st = 3;
    end else begin
      if (!s) begin
        m_low++;
        if (m_low == RS) begin
          m_st = 0;
          m_rs = 1'b1;
        end
      end else begin
        if (m_low > 0) m_err = 1'b1;
        m_low = 0;
      end
    end
    if (m_st != 3) m_low = 0;
    m_t++;
  endtask

  task automatic check_all();
    chk("state", 8'(o_state), 8'(m_st));
    chk("link_mux", 8'(o_link_mux), 8'(mux_of(m_st)));
    chk("no_frame", 8'(o_no_frame_de_assertion), 8'(m_cap));
    chk("frame_pulse", 8'(o_frame_pulse), 8'(m_t > 0 && cur_oct() == F - 1));
    chk("lmfc_pulse", 8'(o_lmfc_pulse),
        8'(m_t > 0 && cur_oct() == F - 1 && cur_frm() == K - 1));
    chk("sync_err", 8'(o_sync_err), 8'(m_err));
    chk("resync", 8'(o_resync), 8'(m_rs));
  endtask

  task automatic step(input logic s, input logic e);
    sync_n  = s;
    link_en = e;
    @(posedge clk);
    model_edge(s, e);
    #1;
    check_all();
  endtask

  task automatic run_to_ila(input string tag);
    int i;
    for (i = 0; i < 2 * MF && m_st != 2; i++) step(1'b1, 1'b1);
    chk(tag, 8'(m_st == 2), 8'd1);
  endtask

  initial begin
    int tgt;
    int n_ila;
    rst_n   = 1'b1;
    sync_n  = 1'b0;
    link_en = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset released with SYNC~ low: stay in CGS, pulses keep running.
    repeat (100) step(1'b0, 1'b1);

    // SYNC~ rise during frame 2, random octet.
    tgt = $urandom_range(0, F - 1);
    for (int i = 0; i < 2 * MF && !(cur_frm() == 2 && cur_oct() == tgt); i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("t2_capture", 8'(o_no_frame_de_assertion), 8'd2);
    chk("t2_wait_state", 8'(o_state), 8'd1);
    n_ila = 0;
    for (int i = 0; i < MF + ILA_LEN + 10; i++) begin
      step(1'b1, 1'b1);
      if (o_link_mux === 3'd2) n_ila++;
    end
    chk("t2_ila_len", 8'(n_ila), 8'(ILA_LEN));
    chk("t2_data_mux", 8'(o_link_mux), 8'd0);

    // Short SYNC~ lows in DATA.
    repeat (20) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("t3_err20", 8'(o_sync_err), 8'd1);
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(1, 10)) step(1'b1, 1'b1);
      repeat ($urandom_range(1, RS - 1)) step(1'b0, 1'b1);
    end
    repeat (3) step(1'b1, 1'b1);

    // Threshold boundary: 48 lows is an error, 49 lows is a resync.
    repeat (RS - 1) step(1'b0, 1'b1);
    chk("t4_still_data", 8'(o_link_mux), 8'd0);
    step(1'b1, 1'b1);
    chk("t4_err48", 8'(o_sync_err), 8'd1);
    repeat (4) step(1'b1, 1'b1);
    repeat (RS) step(1'b0, 1'b1);
    chk("t4_resync", 8'(o_resync), 8'd1);
    chk("t4_resync_mux", 8'(o_link_mux), 8'd1);

    // SYNC~ drop in the third ILA multiframe, then a full re-run.
    step(1'b1, 1'b1);
    run_to_ila("t5_reach_ila");
    repeat (2 * MF + $urandom_range(0, MF - 2)) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk("t5_abort_mux", 8'(o_link_mux), 8'd1);
    repeat (3) step(1'b0, 1'b1);
    n_ila = 0;
    for (int i = 0; i < MF + ILA_LEN + 10; i++) begin
      step(1'b1, 1'b1);
      if (o_link_mux === 3'd2) n_ila++;
    end
    chk("t5_ila_len", 8'(n_ila), 8'(ILA_LEN));

    // Enable drop in DATA, then asynchronous reset in ILA.
    step(1'b1, 1'b0);
    chk("t6_en_state", 8'(o_state), 8'd0);
    chk("t6_en_noresync", 8'(o_resync), 8'd0);
    step(1'b1, 1'b1);
    run_to_ila("t6_reach_ila");
    repeat ($urandom_range(5, 60)) step(1'b1, 1'b1);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      int mode;
      mode = $urandom_range(0, 9);
      if (mode == 0) step(1'b1, 1'b0);
      else if (mode < 4) repeat ($urandom_range(1, 60)) step(1'b0, 1'b1);
      else repeat ($urandom_range(1, 200)) step(1'b1, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
